// File: rtl/led_mux_gen.sv
// -----------------------------------------------------------------------------
// led_mux_gen
//
// Time-multiplexed driver for NUM_DIGITS active-low 7-segment + dp digits.
// Each digit owns a slot of 2**REFRESH_W clock cycles. A slot opens with
// DEAD_CYCLES all-off cycles so the previous digit's anode has fully released
// before the next one is driven (anti-ghosting). After that the digit is lit
// whenever the PWM brightness rule and the blink phase allow it.
//
// The digit pattern, its blink enable and the brightness are copied into
// shadow registers at the first cycle of the slot. Register writes from the
// display core therefore never tear a digit mid-slot.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high; blanks the display immediately
//   en          1 = display on, 0 = blank an/sseg (scan keeps running)
//   digits      digit i segment pattern at [i*SEG_W +: SEG_W], active low
//   blink_mask  bit i = 1 makes digit i blink with the blink counter MSB
//   brightness  0 = off, all-ones = full on, otherwise PWM duty
//   an          anode enables, one-hot-low while a digit is lit, else all 1
//   sseg        segments of the lit digit, all 1 when nothing is lit
//   digit_idx   index of the digit owning the current slot
//   frame_tick  one-cycle pulse at the end of every full scan
// -----------------------------------------------------------------------------
module led_mux_gen #(
  parameter int NUM_DIGITS  = 8,
  parameter int SEG_W       = 8,
  parameter int REFRESH_W   = 16,
  parameter int DEAD_CYCLES = 64,
  parameter int BRIGHT_W    = 4,
  parameter int BLINK_W     = 24,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [NUM_DIGITS*SEG_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  input  logic [BRIGHT_W-1:0]         brightness,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [SEG_W-1:0]            sseg,
  output logic [IDX_W-1:0]            digit_idx,
  output logic                        frame_tick
);

  localparam logic [REFRESH_W-1:0] SLOT_LAST = '1;
  localparam logic [REFRESH_W-1:0] DEAD_END  = REFRESH_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  logic [REFRESH_W-1:0] slot_cnt;
  logic [IDX_W-1:0]     idx;
  logic [BLINK_W-1:0]   blink_cnt;

  // Per-slot shadow copies of the inputs
  logic [SEG_W-1:0]     sh_seg;
  logic                 sh_blink;
  logic [BRIGHT_W-1:0]  sh_bright;

  // Derived per-cycle control
  logic [BRIGHT_W-1:0]  pwm_ph;
  logic                 pwm_on;
  logic                 blink_ph;
  logic                 lit;
  logic [NUM_DIGITS-1:0] an_sel;

  // Unpack the flat digit bus so the active digit can be picked by index.
  logic [SEG_W-1:0] digit_arr [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
    assign digit_arr[gi] = digits[gi*SEG_W +: SEG_W];
  end

  // Slot counter, digit index and blink counter all free-run; only reset
  // restarts the scan. The index advances on the last cycle of each slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt  <= '0;
      idx       <= '0;
      blink_cnt <= '0;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      if (slot_cnt == SLOT_LAST) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Shadow latch at slot start. Slot cycle 0 is always a dead cycle, so the
  // stale shadow contents are never visible while the new copy is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_seg    <= '1;
      sh_blink  <= 1'b1;
      sh_bright <= '1;
    end else if (slot_cnt == '0) begin
      sh_seg    <= digit_arr[idx];
      sh_blink  <= blink_mask[idx];
      sh_bright <= brightness;
    end
  end

  // PWM uses the low slot-counter bits as its phase; all-ones brightness is
  // forced fully on since the strict compare would otherwise miss one phase.
  assign pwm_ph   = slot_cnt[BRIGHT_W-1:0];
  assign pwm_on   = (sh_bright == '1) || (pwm_ph < sh_bright);
  assign blink_ph = blink_cnt[BLINK_W-1];
  assign lit      = en && (slot_cnt >= DEAD_END) && pwm_on && !(sh_blink && blink_ph);
  assign an_sel   = ~(NUM_DIGITS'(1) << idx);

  // Registered outputs: one cycle behind the counter state they decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= '1;
      sseg       <= '1;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else begin
      an         <= lit ? an_sel : '1;
      sseg       <= lit ? sh_seg : '1;
      digit_idx  <= idx;
      frame_tick <= (slot_cnt == SLOT_LAST) && (idx == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_led_mux_gen.sv
// -----------------------------------------------------------------------------
// tb_led_mux_gen
//
// Drives led_mux_gen with directed scenarios followed by random stimulus.
// The reference model tracks only the number of clock edges since reset and
// derives slot position, digit, blink phase and frame position from it with
// plain arithmetic. Literal expectations pin down the model itself.
// -----------------------------------------------------------------------------
module tb_led_mux_gen;

  localparam int ND    = 4;
  localparam int SW    = 8;
  localparam int RW    = 4;
  localparam int DC    = 2;
  localparam int BW    = 2;
  localparam int KW    = 8;
  localparam int SLOT  = 16;
  localparam int FRAME = 64;
  localparam int BLINK_PERIOD = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b0;
  logic [ND*SW-1:0]  digits = '0;
  logic [ND-1:0]     blink_mask = '0;
  logic [BW-1:0]     brightness = '0;
  logic [ND-1:0]     an;
  logic [SW-1:0]     sseg;
  logic [1:0]        digit_idx;
  logic              frame_tick;

  int assertions = 0;
  int failures   = 0;

  // Model state
  int             t = 0;
  logic [SW-1:0]  m_seg = '1;
  logic           m_blink = 1'b1;
  logic [BW-1:0]  m_bright = '1;
  logic [ND-1:0]  exp_an = '1;
  logic [SW-1:0]  exp_sseg = '1;
  logic [1:0]     exp_idx = '0;
  logic           exp_tick = 1'b0;
  int             m_prev_slot = 0;

  // Observation state
  bit check_on = 1'b0;
  int cyc = 0;
  int lit_count = 0;
  int last_tick = -1;
  int tick_interval = 0;

  led_mux_gen #(
    .NUM_DIGITS (ND),
    .SEG_W      (SW),
    .REFRESH_W  (RW),
    .DEAD_CYCLES(DC),
    .BRIGHT_W   (BW),
    .BLINK_W    (KW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .digits     (digits),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .an         (an),
    .sseg       (sseg),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [ND*SW-1:0] d,
                               input logic [ND-1:0] m, input logic [BW-1:0] b);
    en         = e;
    digits     = d;
    blink_mask = m;
    brightness = b;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next falling edge at which the model's frame position is p.
  task automatic waitPhase(input int p);
    int n;
    n = 0;
    @(negedge clk);
    while ((t % FRAME) != p && n < 4*FRAME) begin
      @(negedge clk);
      n++;
    end
    if ((t % FRAME) != p) begin
      assertions++;
      failures++;
      $display("[TB] FAIL wait_phase: got %0d expected %0d", t % FRAME, p);
    end
  endtask

  // Sample the outputs produced from the current state and compare to literals.
  task automatic checkNext(input string name, input logic [ND-1:0] a, input logic [SW-1:0] s);
    @(posedge clk);
    #1;
    checkOutput({name, "_an"}, an, a);
    checkOutput({name, "_sseg"}, sseg, s);
  endtask

  // Reference model: everything follows from t, the number of clock edges
  // seen since reset released. Expected outputs describe the state of cycle t.
  initial begin
    int slot, dig;
    bit bph, pwm_on, lit;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        t           = 0;
        m_seg       = '1;
        m_blink     = 1'b1;
        m_bright    = '1;
        exp_an      = '1;
        exp_sseg    = '1;
        exp_idx     = '0;
        exp_tick    = 1'b0;
        m_prev_slot = 0;
      end else begin
        slot   = t % SLOT;
        dig    = (t / SLOT) % ND;
        bph    = (t % BLINK_PERIOD) >= (BLINK_PERIOD / 2);
        pwm_on = (m_bright == 2'd3) || ((slot % 4) < int'(m_bright));
        lit    = en && (slot >= DC) && pwm_on && !(m_blink && bph);
        exp_an      = lit ? ~(4'b0001 << dig) : 4'hF;
        exp_sseg    = lit ? m_seg : 8'hFF;
        exp_idx     = 2'(dig);
        exp_tick    = (t % FRAME) == FRAME - 1;
        m_prev_slot = slot;
        if (slot == 0) begin
          m_seg    = digits[dig*SW +: SW];
          m_blink  = blink_mask[dig];
          m_bright = brightness;
        end
        t++;
      end
    end
  end

  // Compare process: every cycle, just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (check_on) begin
        checkOutput("an", an, exp_an);
        checkOutput("sseg", sseg, exp_sseg);
        checkOutput("digit_idx", digit_idx, exp_idx);
        checkOutput("frame_tick", frame_tick, exp_tick);
        checkOutput("an_onehot", ($countones(~an) <= 1), 1);
        if (m_prev_slot < DC) checkOutput("dead_time_an", an, 4'hF);
        if (an != 4'hF) lit_count++;
        if (frame_tick === 1'b1) begin
          if (last_tick >= 0) tick_interval = cyc - last_tick;
          last_tick = cyc;
          checkOutput("tick_idx", digit_idx, ND - 1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam logic [ND*SW-1:0] DIGITS_T1 = {8'h0F, 8'h3C, 8'hA5, 8'h81};

  initial begin
    logic [ND-1:0] lit_an  [ND];
    logic [SW-1:0] lit_seg [ND];
    int            bright_cnt [4];
    lit_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    lit_seg = '{8'h81, 8'hA5, 8'h3C, 8'h0F};
    bright_cnt = '{0, 12, 24, 56};

    // T1: reset values, first lit cycle, per-digit patterns, frame period
    #2 reset = 1'b1;
    @(negedge clk);
    check_on = 1'b1;
    applyStimulus(1'b1, DIGITS_T1, 4'b0000, 2'd3);
    tick(2);
    checkOutput("reset_an", an, 4'hF);
    checkOutput("reset_sseg", sseg, 8'hFF);
    checkOutput("reset_idx", digit_idx, 0);
    checkOutput("reset_tick", frame_tick, 0);
    reset = 1'b0;
    checkNext("cyc1", 4'hF, 8'hFF);
    checkNext("cyc2", 4'hF, 8'hFF);
    checkNext("cyc3", 4'b1110, 8'h81);

    for (int d = 0; d < ND; d++) begin
      waitPhase(d*SLOT + 8);
      checkNext("t1_digit", lit_an[d], lit_seg[d]);
    end
    tick(2*FRAME);
    checkOutput("tick_interval", tick_interval, FRAME);

    // T2: brightness duty measured over whole frames
    for (int b = 3; b >= 0; b--) begin
      applyStimulus(1'b1, DIGITS_T1, 4'b0000, 2'(b));
      waitPhase(0);
      tick(FRAME);
      lit_count = 0;
      tick(FRAME);
      checkOutput("bright_lit_count", lit_count, bright_cnt[b]);
    end

    // T3: digit1 blinks, others unaffected, over one full blink period
    applyStimulus(1'b1, DIGITS_T1, 4'b0010, 2'd3);
    waitPhase(0);
    tick(FRAME);
    lit_count = 0;
    tick(BLINK_PERIOD);
    checkOutput("blink_lit_count", lit_count, 196);

    // T4: mid-slot changes only land at the next slot start
    applyStimulus(1'b1, DIGITS_T1, 4'b0000, 2'd3);
    tick(FRAME);
    waitPhase(SLOT + 7);
    applyStimulus(1'b1, {8'h0F, 8'h3C, 8'h5A, 8'h81}, 4'b0000, 2'd0);
    waitPhase(SLOT + 12);
    checkNext("t4_same_slot", 4'b1101, 8'hA5);
    waitPhase(2*SLOT + 8);
    checkNext("t4_next_slot_dark", 4'hF, 8'hFF);
    applyStimulus(1'b1, {8'h0F, 8'h3C, 8'h5A, 8'h81}, 4'b0000, 2'd3);
    waitPhase(SLOT + 8);
    checkNext("t4_new_digit", 4'b1101, 8'h5A);

    // T5: en low for five cycles mid-slot
    waitPhase(2*SLOT + 8);
    en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_blank_an", an, 4'hF);
    checkOutput("t5_blank_sseg", sseg, 8'hFF);
    checkOutput("t5_idx", digit_idx, 2);
    tick(5);
    en = 1'b1;
    checkNext("t5_resume", 4'b1011, 8'h3C);

    // T6: asynchronous reset mid-slot, then restart from digit 0
    waitPhase(2*SLOT + 9);
    reset = 1'b1;
    #1;
    checkOutput("t6_async_an", an, 4'hF);
    checkOutput("t6_async_sseg", sseg, 8'hFF);
    checkOutput("t6_async_idx", digit_idx, 0);
    tick(2);
    last_tick = -1;
    reset = 1'b0;
    checkNext("t6_cyc1", 4'hF, 8'hFF);
    checkNext("t6_cyc2", 4'hF, 8'hFF);
    checkNext("t6_cyc3", 4'b1110, 8'h81);

    // Random stimulus checked cycle by cycle against the model
    @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) digits = {$urandom, $urandom};
      if ($urandom_range(0, 49) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 29) == 0) brightness = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        last_tick = -1;
        @(negedge clk);
        reset = 1'b0;
      end
      @(negedge clk);
    end

    check_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
